// File: rtl/pooling_pkg.sv
// Shared definitions for the 2x2 pooling window front-end: pixel width,
// default feature-map geometry and the row-parity FSM state type.
package pooling_pkg;

  localparam int LATIME_PIXEL      = 8;
  localparam int LATIME_IMPLICIT   = 28;
  localparam int INALTIME_IMPLICIT = 28;

  typedef enum logic [1:0] {
    ASTEAPTA   = 2'd0,
    RAND_PAR   = 2'd1,
    RAND_IMPAR = 2'd2
  } stare_fereastra_t;

endpackage

// File: rtl/linie_buffer.sv
// One-row pixel store: synchronous write, asynchronous (combinational) read.
// Contents are deliberately left unreset; every cell is rewritten before use.
module linie_buffer
  import pooling_pkg::*;
#(
  parameter  int ADANCIME = LATIME_IMPLICIT,
  localparam int AW       = (ADANCIME > 1) ? $clog2(ADANCIME) : 1
) (
  input  logic                    clk,
  input  logic                    i_wr_en,
  input  logic [AW-1:0]           i_wr_addr,
  input  logic [LATIME_PIXEL-1:0] i_wr_data,
  input  logic [AW-1:0]           i_rd_addr,
  output logic [LATIME_PIXEL-1:0] o_rd_data
);

  logic [LATIME_PIXEL-1:0] r_mem [ADANCIME];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fereastra_2x2.sv
// Builds non-overlapping 2x2 windows from a raster pixel stream: even rows are
// parked in a line buffer, odd rows pair with them two columns at a time.
module fereastra_2x2
  import pooling_pkg::*;
#(
  parameter int LATIME   = LATIME_IMPLICIT,
  parameter int INALTIME = INALTIME_IMPLICIT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pixel_valid,
  input  logic [LATIME_PIXEL-1:0] pixel_in,
  output logic [LATIME_PIXEL-1:0] fereastra1,
  output logic [LATIME_PIXEL-1:0] fereastra2,
  output logic [LATIME_PIXEL-1:0] fereastra3,
  output logic [LATIME_PIXEL-1:0] fereastra4,
  output logic                    activare_tragere,
  output logic                    cadru_gata
);

  localparam int CW = $clog2(LATIME);
  localparam int RW = $clog2(INALTIME);
  localparam logic [CW-1:0] COL_MAX  = CW'(LATIME - 1);
  localparam logic [RW-1:0] RAND_MAX = RW'(INALTIME - 1);
  localparam logic [CW-1:0] COL_UNU  = CW'(1);
  localparam logic [RW-1:0] RAND_UNU = RW'(1);

  stare_fereastra_t        r_stare;
  logic [CW-1:0]           r_col;
  logic [RW-1:0]           r_rand;
  logic [LATIME_PIXEL-1:0] r_sus_stanga;
  logic [LATIME_PIXEL-1:0] r_jos_stanga;
  logic [LATIME_PIXEL-1:0] r_f1;
  logic [LATIME_PIXEL-1:0] r_f2;
  logic [LATIME_PIXEL-1:0] r_f3;
  logic [LATIME_PIXEL-1:0] r_f4;
  logic                    r_activare;
  logic                    r_cadru;

  logic                    w_rand_impar;
  logic                    w_sfarsit_rand;
  logic                    w_sfarsit_cadru;
  logic                    w_scrie_buffer;
  logic                    w_latch_stanga;
  logic                    w_emite;
  logic [LATIME_PIXEL-1:0] w_buf_rd;

  assign w_rand_impar    = (r_stare == RAND_IMPAR);
  assign w_sfarsit_rand  = pixel_valid && (r_col == COL_MAX);
  assign w_sfarsit_cadru = w_sfarsit_rand && (r_rand == RAND_MAX);

  // ASTEAPTA also writes: the very first pixel of a frame belongs to row 0.
  assign w_scrie_buffer  = pixel_valid && !w_rand_impar;
  assign w_latch_stanga  = pixel_valid && w_rand_impar && !r_col[0];
  assign w_emite         = pixel_valid && w_rand_impar && r_col[0];

  linie_buffer #(
    .ADANCIME (LATIME)
  ) u_linie_buffer (
    .clk       (clk),
    .i_wr_en   (w_scrie_buffer),
    .i_wr_addr (r_col),
    .i_wr_data (pixel_in),
    .i_rd_addr (r_col),
    .o_rd_data (w_buf_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stare      <= ASTEAPTA;
      r_col        <= '0;
      r_rand       <= '0;
      r_sus_stanga <= '0;
      r_jos_stanga <= '0;
      r_f1         <= '0;
      r_f2         <= '0;
      r_f3         <= '0;
      r_f4         <= '0;
      r_activare   <= 1'b0;
      r_cadru      <= 1'b0;
    end else begin
      r_activare <= w_emite;
      r_cadru    <= w_sfarsit_cadru;

      if (pixel_valid) begin
        if (w_sfarsit_rand) begin
          r_col  <= '0;
          r_rand <= w_sfarsit_cadru ? '0 : (r_rand + RAND_UNU);
        end else begin
          r_col <= r_col + COL_UNU;
        end

        unique case (r_stare)
          ASTEAPTA: begin
            r_stare <= w_sfarsit_rand ? RAND_IMPAR : RAND_PAR;
          end
          RAND_PAR: begin
            if (w_sfarsit_cadru) begin
              r_stare <= ASTEAPTA;
            end else if (w_sfarsit_rand) begin
              r_stare <= RAND_IMPAR;
            end
          end
          RAND_IMPAR: begin
            if (w_sfarsit_cadru) begin
              r_stare <= ASTEAPTA;
            end else if (w_sfarsit_rand) begin
              r_stare <= RAND_PAR;
            end
          end
          default: begin
            r_stare <= ASTEAPTA;
          end
        endcase
      end

      // Left half of the window waits here until its right partner arrives.
      if (w_latch_stanga) begin
        r_sus_stanga <= w_buf_rd;
        r_jos_stanga <= pixel_in;
      end

      if (w_emite) begin
        r_f1 <= r_sus_stanga;
        r_f2 <= w_buf_rd;
        r_f3 <= r_jos_stanga;
        r_f4 <= pixel_in;
      end
    end
  end

  assign fereastra1       = r_f1;
  assign fereastra2       = r_f2;
  assign fereastra3       = r_f3;
  assign fereastra4       = r_f4;
  assign activare_tragere = r_activare;
  assign cadru_gata       = r_cadru;

endmodule

// File: tb/tb_fereastra_2x2.sv
// Scoreboard bench: a 4x4 and a 5x4 instance, expected windows derived from
// frame coordinates and compared by free-running monitors.
module tb_fereastra_2x2;

  typedef struct {
    logic [31:0] w;
    int          cyc;
  } win_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v0, v1;
  logic [7:0] d0, d1;
  logic [7:0] f0_1, f0_2, f0_3, f0_4, f1_1, f1_2, f1_3, f1_4;
  logic       act0, act1, cad0, cad1;

  always #5 clk = ~clk;

  fereastra_2x2 #(.LATIME(4), .INALTIME(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .pixel_valid(v0), .pixel_in(d0),
    .fereastra1(f0_1), .fereastra2(f0_2), .fereastra3(f0_3), .fereastra4(f0_4),
    .activare_tragere(act0), .cadru_gata(cad0)
  );

  fereastra_2x2 #(.LATIME(5), .INALTIME(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .pixel_valid(v1), .pixel_in(d1),
    .fereastra1(f1_1), .fereastra2(f1_2), .fereastra3(f1_3), .fereastra4(f1_4),
    .activare_tragere(act1), .cadru_gata(cad1)
  );

  win_t        wq0[$];
  win_t        wq1[$];
  int          cq0[$];
  int          cq1[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [7:0]  fr [2][4][5];
  int          pr[2];
  int          pc[2];
  logic [31:0] last0, last1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: actual=strobe required=none at cycle %0d", nm, cyc);
  endtask

  // Reference: remember every pixel by (row, col); odd/odd positions close a window.
  task automatic model(input int k, input logic [7:0] d);
    int   w;
    int   r;
    int   c;
    win_t x;
    w = (k == 0) ? 4 : 5;
    r = pr[k];
    c = pc[k];
    fr[k][r][c] = d;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      x.w   = {fr[k][r-1][c-1], fr[k][r-1][c], fr[k][r][c-1], d};
      x.cyc = cyc + 1;
      if (k == 0) wq0.push_back(x);
      else        wq1.push_back(x);
    end
    if ((r == 3) && (c == w - 1)) begin
      if (k == 0) cq0.push_back(cyc + 1);
      else        cq1.push_back(cyc + 1);
    end
    c++;
    if (c == w) begin
      c = 0;
      r = (r == 3) ? 0 : r + 1;
    end
    pr[k] = r;
    pc[k] = c;
  endtask

  task automatic px(input int k, input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
    if (k == 0) begin v0 = v; d0 = d; end
    else        begin v1 = v; d1 = d; end
    if (v) model(k, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      v0 = 1'b0;
      v1 = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    v0    = 1'b0;
    v1    = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_win0", {f0_1, f0_2, f0_3, f0_4}, 32'h0);
    chk("rst_act0", 32'(act0), 32'h0);
    chk("rst_cad0", 32'(cad0), 32'h0);
    chk("rst_win1", {f1_1, f1_2, f1_3, f1_4}, 32'h0);
    chk("rst_act1", 32'(act1), 32'h0);
    chk("rst_cad1", 32'(cad1), 32'h0);
    wq0.delete();
    wq1.delete();
    cq0.delete();
    cq1.delete();
    pr    = '{0, 0};
    pc    = '{0, 0};
    last0 = 32'h0;
    last1 = 32'h0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : mon0
    win_t x;
    if (rst_n) begin
      if (act0) begin
        if (wq0.size() == 0) unexpected("strobe0");
        else begin
          x = wq0.pop_front();
          chk("win0", {f0_1, f0_2, f0_3, f0_4}, x.w);
          chk("lat0", 32'(cyc), 32'(x.cyc));
          last0 = x.w;
        end
      end else begin
        chk("hold0", {f0_1, f0_2, f0_3, f0_4}, last0);
      end
      if (cad0) begin
        if (cq0.size() == 0) unexpected("cadru0");
        else chk("cadru0_cyc", 32'(cyc), 32'(cq0.pop_front()));
      end
    end
  end

  always @(negedge clk) begin : mon1
    win_t x;
    if (rst_n) begin
      if (act1) begin
        if (wq1.size() == 0) unexpected("strobe1");
        else begin
          x = wq1.pop_front();
          chk("win1", {f1_1, f1_2, f1_3, f1_4}, x.w);
          chk("lat1", 32'(cyc), 32'(x.cyc));
          last1 = x.w;
        end
      end else begin
        chk("hold1", {f1_1, f1_2, f1_3, f1_4}, last1);
      end
      if (cad1) begin
        if (cq1.size() == 0) unexpected("cadru1");
        else chk("cadru1_cyc", 32'(cyc), 32'(cq1.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    d0 = 8'h0; d1 = 8'h0;
    do_reset();

    // 4x4 back-to-back, then with valid toggling
    for (int i = 0; i < 16; i++) px(0, 1'b1, 8'(i));
    idle(3);
    for (int i = 0; i < 16; i++) begin
      px(0, 1'b1, 8'(i));
      px(0, 1'b0, 8'hEE);
    end
    idle(3);

    // abandoned partial frame, then a clean one
    for (int i = 0; i < 7; i++) px(0, 1'b1, 8'(i));
    idle(1);
    do_reset();
    for (int i = 100; i < 116; i++) px(0, 1'b1, 8'(i));
    idle(3);

    // two frames with no gap
    for (int i = 0; i < 32; i++) px(0, 1'b1, 8'($urandom));
    idle(3);

    // odd width
    for (int i = 0; i < 20; i++) px(1, 1'b1, 8'(i));
    idle(3);

    // random pixels and random gaps
    for (int i = 0; i < 200; i++) px(1, ($urandom_range(0, 3) != 0), 8'($urandom));
    idle(3);
    for (int i = 0; i < 150; i++) px(0, ($urandom_range(0, 2) != 0), 8'($urandom));
    idle(4);

    chk("pending0", 32'(wq0.size() + cq0.size()), 32'h0);
    chk("pending1", 32'(wq1.size() + cq1.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
